div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 2, number of requesters; DIVIDEND_WIDTH, default 64, dividend/quotient width; DIVISOR_WIDTH, default 32, divisor/remainder width.
REQ-002 Clocking SHALL be one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  sync active-high reset
- req_valid  in  NUM_REQ  per-requester divide request
- req_ready  out  NUM_REQ  per-requester accept strobe, one-hot or zero
- req_dividend  in  NUM_REQ x DIVIDEND_WIDTH  signed dividends
- req_divisor  in  NUM_REQ x DIVISOR_WIDTH  signed divisors
- rsp_valid  out  NUM_REQ  one-cycle result strobe to the owning requester
- rsp_quotient  out  DIVIDEND_WIDTH  shared result quotient
- rsp_remainder  out  DIVISOR_WIDTH  shared result remainder
- rsp_overflow  out  1  overflow or divide-by-zero flag
- div_valid_in  out  1  start pulse to the shared div instance
- div_dividend  out  DIVIDEND_WIDTH  registered operand to div
- div_divisor  out  DIVISOR_WIDTH  registered operand to div
- div_quotient  in  DIVIDEND_WIDTH  div result
- div_remainder  in  DIVISOR_WIDTH  div result
- div_overflow  in  1  div overflow
- div_valid_out  in  1  div completion pulse
- spurious_err  out  1  sticky flag: div_valid_out seen while not in WAIT

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and RESPOND; transitions: IDLE->ISSUE on grant with nonzero divisor; IDLE->RESPOND on grant with zero divisor; ISSUE->WAIT unconditionally; WAIT->RESPOND on div_valid_out; RESPOND->IDLE unconditionally.
REQ-005 In IDLE, req_ready SHALL be asserted combinationally to exactly one requester (the round-robin winner among asserted req_valid); it SHALL be zero in all other states.
REQ-006 Round-robin SHALL search from (last_grant+1) mod NUM_REQ upward; after reset, last_grant SHALL equal NUM_REQ-1, so requester 0 has first priority.
REQ-007 On grant, the block SHALL capture the operands, the owner index and last_grant in flops; requesters SHALL hold valid and operands stable until ready.
REQ-008 In ISSUE, div_valid_in SHALL be 1 for exactly one cycle with captured operands on div_dividend/div_divisor.
REQ-009 In WAIT, the block SHALL latch div_quotient, div_remainder and div_overflow on the div_valid_out cycle.
REQ-010 In RESPOND, rsp_valid[owner] SHALL be 1 for one cycle, with the latched results on rsp_* ; the rsp_* buses SHALL hold their value until the next RESPOND.
REQ-011 Latency: a handshake at cycle T SHALL give div_valid_in at T+1 and rsp_valid at D+1, where D is the div_valid_out cycle.
REQ-012 If the divisor is zero, the divider SHALL NOT be started; rsp_valid SHALL fire at T+1 with rsp_overflow=1, rsp_quotient=0 and rsp_remainder=0.
REQ-013 Arbitration and IDLE behaviour:
- Back-to-back service SHALL be guaranteed: IDLE after RESPOND re-arbitrates immediately.
- Simultaneous requests from all requesters SHALL be served strictly in rotation.
- A request dropped before ready SHALL be ignored.
REQ-014 div_valid_out in any state other than WAIT SHALL be ignored for data and SHALL set spurious_err, cleared only by reset.

Reset
REQ-015 Reset SHALL force state=IDLE, req_ready=0, rsp_valid=0, rsp_quotient=0, rsp_remainder=0, rsp_overflow=0, div_valid_in=0, div_dividend=0, div_divisor=0, spurious_err=0 and last_grant=NUM_REQ-1.
REQ-016 Reset mid-operation SHALL abandon the transaction with no rsp_valid; the divider shares the same reset.

Structure
REQ-017 Package div_arb_pkg SHALL hold the state enum and the parameter defaults.
REQ-018 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant, grant index).

Verification
REQ-019 Single request: req 0, dividend -100, divisor 7 -> div_valid_in at T+1; rsp_valid[0] with quotient -14, remainder -2, overflow 0.
REQ-020 Contention: req 0 and req 1 held continuously -> grants alternate 0,1,0,1; after reset the first grant goes to 0.
REQ-021 Zero divisor: req 1, dividend 5, divisor 0 -> no div_valid_in; rsp_valid[1] at T+1 with overflow=1, quotient 0, remainder 0.
REQ-022 Reset asserted during WAIT -> no rsp_valid; IDLE next cycle; the next grant goes to requester 0.
REQ-023 Spurious div_valid_out in IDLE -> spurious_err=1 sticky; rsp_* unchanged.
REQ-024 Back-to-back requests: 8 requests alternating between requesters -> every request gets exactly one rsp_valid to the correct owner, in grant order.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared types and parameter defaults for the divider arbiter.
package div_arb_pkg;

   localparam int unsigned DEF_NUM_REQ        = 2;
   localparam int unsigned DEF_DIVIDEND_WIDTH = 64;
   localparam int unsigned DEF_DIVISOR_WIDTH  = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESPOND
   } arb_state_e;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches upward from the requester after last_grant.
module rr_arbiter
   import div_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned IDX_W   = idx_width(DEF_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // First asserted request in rotation order starting at last_grant+1 wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((32'(last_grant) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// Shares one divider between NUM_REQ requesters with round-robin arbitration.
module div_arbiter
   import div_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
   parameter int unsigned DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
   parameter int unsigned DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_REQ-1:0]                       req_valid,
   output logic [NUM_REQ-1:0]                       req_ready,
   input  logic [NUM_REQ-1:0][DIVIDEND_WIDTH-1:0]   req_dividend,
   input  logic [NUM_REQ-1:0][DIVISOR_WIDTH-1:0]    req_divisor,
   output logic [NUM_REQ-1:0]                       rsp_valid,
   output logic [DIVIDEND_WIDTH-1:0]                rsp_quotient,
   output logic [DIVISOR_WIDTH-1:0]                 rsp_remainder,
   output logic                                     rsp_overflow,
   output logic                                     div_valid_in,
   output logic [DIVIDEND_WIDTH-1:0]                div_dividend,
   output logic [DIVISOR_WIDTH-1:0]                 div_divisor,
   input  logic [DIVIDEND_WIDTH-1:0]                div_quotient,
   input  logic [DIVISOR_WIDTH-1:0]                 div_remainder,
   input  logic                                     div_overflow,
   input  logic                                     div_valid_out,
   output logic                                     spurious_err
);

   localparam int unsigned IDX_W = idx_width(NUM_REQ);

   arb_state_e         state;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic               handshake;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   // Ready is offered only while idle; reset suppresses it so no grant is taken mid-reset.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && !reset) req_ready = grant;
   end

   assign handshake = |req_ready;

   // Sticky error when the divider reports completion outside WAIT.
   always_ff @(posedge clk) begin
      if (reset)                               spurious_err <= 1'b0;
      else if (div_valid_out && state != WAIT) spurious_err <= 1'b1;
   end

   // Transaction FSM: capture on grant, start divider, collect result, respond.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         last_grant    <= IDX_W'(NUM_REQ - 1);
         owner         <= '0;
         rsp_valid     <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
         rsp_overflow  <= 1'b0;
         div_valid_in  <= 1'b0;
         div_dividend  <= '0;
         div_divisor   <= '0;
      end else begin
         div_valid_in <= 1'b0;
         rsp_valid    <= '0;
         case (state)
            IDLE: begin
               if (handshake) begin
                  last_grant   <= grant_idx;
                  owner        <= grant_idx;
                  div_dividend <= req_dividend[grant_idx];
                  div_divisor  <= req_divisor[grant_idx];
                  if (req_divisor[grant_idx] == '0) begin
                     // Divide-by-zero bypasses the divider and answers next cycle.
                     rsp_valid     <= grant;
                     rsp_quotient  <= '0;
                     rsp_remainder <= '0;
                     rsp_overflow  <= 1'b1;
                     state         <= RESPOND;
                  end else begin
                     div_valid_in <= 1'b1;
                     state        <= ISSUE;
                  end
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (div_valid_out) begin
                  rsp_quotient  <= div_quotient;
                  rsp_remainder <= div_remainder;
                  rsp_overflow  <= div_overflow;
                  rsp_valid     <= NUM_REQ'(1) << owner;
                  state         <= RESPOND;
               end
            end
            RESPOND: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divider stand-in.
module tb_div_arbiter;

   localparam int N = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0][63:0] req_dividend = '0;
   logic [N-1:0][31:0] req_divisor = '0;
   logic [N-1:0]      rsp_valid;
   logic [63:0]       rsp_quotient;
   logic [31:0]       rsp_remainder;
   logic              rsp_overflow;
   logic              div_valid_in;
   logic [63:0]       div_dividend;
   logic [31:0]       div_divisor;
   logic [63:0]       div_quotient;
   logic [31:0]       div_remainder;
   logic              div_overflow;
   logic              div_valid_out;
   logic              spurious_err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0]  owner;
      logic [63:0] q;
      logic [31:0] r;
      logic        o;
   } exp_t;

   exp_t        sb[$];
   int          grant_log[$];
   int          model_last = N - 1;
   logic        busy = 0, outstanding = 0, exp_issue = 0, exp_rsp = 0, exp_spur = 0, prev_reset = 0;
   logic [63:0] issue_a = '0;
   logic [31:0] issue_b = '0;
   logic [63:0] hold_q = '0, last_q = '0;
   logic [31:0] hold_r = '0, last_r = '0;
   logic        hold_o = 0, last_o = 0;
   logic [N-1:0] last_rsp = '0;
   int          force_lat = 0;
   logic        spur_req = 0;

   div_arbiter #(.NUM_REQ(N), .DIVIDEND_WIDTH(64), .DIVISOR_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
      .rsp_remainder(rsp_remainder), .rsp_overflow(rsp_overflow),
      .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder),
      .div_overflow(div_overflow), .div_valid_out(div_valid_out),
      .spurious_err(spurious_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Truncating signed division; zero divisor answers overflow with zero results.
   function automatic exp_t ref_div(input int owner, input logic signed [63:0] a,
                                    input logic signed [31:0] b);
      exp_t e;
      logic signed [63:0] bb, rr;
      e.owner = 8'(owner);
      if (b == 0) begin
         e.q = '0; e.r = '0; e.o = 1'b1;
      end else begin
         bb  = b;
         e.q = a / bb;
         rr  = a % bb;
         e.r = rr[31:0];
         e.o = 1'b0;
      end
      return e;
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin : monitor
      logic [N-1:0] hs;
      logic nxt_rsp, rsp_done;
      int w;
      exp_t e;
      nxt_rsp = 0;
      rsp_done = 0;
      if (reset) begin
         if (prev_reset) begin
            chk("reset_ctrl", {req_ready, rsp_valid, rsp_overflow, div_valid_in, spurious_err}, '0);
            chk("reset_rsp", {rsp_quotient, rsp_remainder}, '0);
            chk("reset_div", {div_dividend, div_divisor}, '0);
         end
         sb.delete();
         busy = 0; outstanding = 0; exp_issue = 0; exp_rsp = 0; exp_spur = 0;
         model_last = N - 1;
         hold_q = '0; hold_r = '0; hold_o = 0;
         prev_reset = 1;
      end else begin
         prev_reset = 0;
         if (div_valid_in || exp_issue) begin
            chk("issue_timing", div_valid_in, exp_issue);
            if (div_valid_in && exp_issue) begin
               chk("issue_operands", {div_dividend, div_divisor}, {issue_a, issue_b});
               outstanding = 1;
            end
         end
         exp_issue = 0;
         chk("spurious_err", spurious_err, exp_spur);
         if (div_valid_out) begin
            if (outstanding) begin outstanding = 0; nxt_rsp = 1; end
            else exp_spur = 1;
         end
         if (rsp_valid != 0 || exp_rsp) begin
            chk("rsp_timing", rsp_valid != 0, exp_rsp);
            if (rsp_valid != 0) begin
               if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, '0);
               else begin
                  e = sb.pop_front();
                  chk("rsp_owner", rsp_valid, 2'b01 << e.owner);
                  chk("rsp_result", {rsp_quotient, rsp_remainder, rsp_overflow}, {e.q, e.r, e.o});
                  rsp_done = 1;
               end
               hold_q = rsp_quotient; hold_r = rsp_remainder; hold_o = rsp_overflow;
               last_q = rsp_quotient; last_r = rsp_remainder; last_o = rsp_overflow;
               last_rsp = rsp_valid;
            end
         end else begin
            chk("rsp_hold", {rsp_quotient, rsp_remainder, rsp_overflow}, {hold_q, hold_r, hold_o});
         end
         if (busy) chk("ready_busy", req_ready, '0);
         hs = req_valid & req_ready;
         if (hs != 0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
               if (w < 0 && req_valid[(model_last + k) % N]) w = (model_last + k) % N;
            chk("grant", req_ready, 2'b01 << w);
            grant_log.push_back(req_ready[1] ? 1 : 0);
            model_last = w;
            sb.push_back(ref_div(w, req_dividend[w], req_divisor[w]));
            busy = 1;
            if (req_divisor[w] == 0) nxt_rsp = 1;
            else begin
               exp_issue = 1;
               issue_a = req_dividend[w];
               issue_b = req_divisor[w];
            end
         end else if (!busy) begin
            chk("idle_grant", {req_valid != 0, req_ready}, '0);
         end
         if (rsp_done) busy = 0;
         exp_rsp = nxt_rsp;
      end
   end

   // Divider stand-in: answers after a random or forced latency; can inject a stray completion.
   initial begin : divider
      logic signed [63:0] dv_a, bb, rr;
      logic signed [31:0] dv_b;
      logic dv_pend;
      int dv_cnt;
      dv_pend = 0; dv_cnt = 0; dv_a = '0; dv_b = '0;
      div_valid_out = 0; div_quotient = '0; div_remainder = '0; div_overflow = 0;
      forever begin
         @(negedge clk);
         if (reset) dv_pend = 0;
         else if (div_valid_in) begin
            dv_pend = 1;
            dv_a = div_dividend;
            dv_b = div_divisor;
            dv_cnt = (force_lat > 0) ? force_lat : int'($urandom_range(0, 5));
         end
         @(posedge clk); #1;
         div_valid_out = 0;
         if (spur_req) begin
            spur_req = 0;
            div_valid_out = 1;
            div_quotient = {$urandom, $urandom};
            div_remainder = $urandom;
            div_overflow = 1;
         end else if (dv_pend) begin
            if (dv_cnt == 0) begin
               dv_pend = 0;
               bb = dv_b;
               rr = dv_a % bb;
               div_quotient = dv_a / bb;
               div_remainder = rr[31:0];
               div_overflow = (dv_a == 64'h8000_0000_0000_0000) && (dv_b == -1);
               div_valid_out = 1;
            end else dv_cnt--;
         end
      end
   end

   task automatic do_req(input int i, input logic [63:0] a, input logic [31:0] b);
      int cnt;
      logic acc;
      cnt = 0; acc = 0;
      req_dividend[i] = a;
      req_divisor[i] = b;
      req_valid[i] = 1'b1;
      while (!acc && cnt < 300) begin
         @(negedge clk);
         acc = req_ready[i];
         cnt++;
      end
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      if (!acc) chk("req_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int cnt;
      cnt = 0;
      do begin
         @(posedge clk);
         cnt++;
      end while ((busy || sb.size() != 0) && cnt < 300);
      #1;
      if (cnt >= 300) chk("idle_timeout", 0, 1);
   endtask

   task automatic apply_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   function automatic logic [63:0] rnd_a();
      logic [63:0] a;
      if ($urandom_range(0, 1) == 0) begin
         a = 64'($urandom_range(0, 2000));
         a = a - 64'd1000;
      end else a = {$urandom, $urandom};
      if (a == 64'h8000_0000_0000_0000) a = 64'd1;
      return a;
   endfunction

   function automatic logic [31:0] rnd_b();
      logic [31:0] b;
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) b = '0;
      else if (sel <= 3) begin
         b = 32'($urandom_range(1, 40));
         if ($urandom_range(0, 1) == 1) b = -b;
      end else b = $urandom;
      return b;
   endfunction

   initial begin : stimulus
      apply_reset(3);

      // single request: -100 / 7
      do_req(0, -64'sd100, 32'sd7);
      wait_idle();
      chk("dir_single", {last_rsp, last_q, last_r, last_o},
          {2'b01, 64'hFFFF_FFFF_FFFF_FFF2, 32'hFFFF_FFFE, 1'b0});

      // zero divisor
      do_req(1, 64'd5, 32'd0);
      wait_idle();
      chk("dir_zero", {last_rsp, last_q, last_r, last_o}, {2'b10, 64'd0, 32'd0, 1'b1});

      // contention straight after reset
      apply_reset(2);
      grant_log.delete();
      fork
         begin for (int k = 0; k < 4; k++) do_req(0, rnd_a(), rnd_b()); end
         begin for (int k = 0; k < 4; k++) do_req(1, rnd_a(), rnd_b()); end
      join
      wait_idle();
      chk("contention_count", grant_log.size(), 8);
      if (grant_log.size() == 8) begin
         logic [7:0] seq;
         seq = '0;
         for (int k = 0; k < 8; k++) seq[k] = grant_log[k][0];
         chk("contention_order", seq, 8'b1010_1010);
      end

      // request raised and withdrawn while the divider is busy
      force_lat = 6;
      fork
         do_req(0, 64'd77, 32'd5);
         begin
            repeat (3) @(posedge clk);
            #1 req_divisor[1] = 32'd3; req_valid[1] = 1'b1;
            repeat (2) @(posedge clk);
            #1 req_valid[1] = 1'b0;
         end
      join
      wait_idle();
      chk("drop_ignored", last_rsp, 2'b01);

      // reset while waiting on the divider
      force_lat = 20;
      do_req(1, 64'd1000, 32'd3);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      force_lat = 0;
      grant_log.delete();
      fork
         do_req(0, 64'd9, 32'd2);
         do_req(1, 64'd9, 32'd4);
      join
      wait_idle();
      chk("post_reset_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

      // stray completion while idle
      spur_req = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("spur_sticky", spurious_err, 1);

      // randomized traffic
      fork
         begin
            for (int k = 0; k < 12; k++) begin
               int gap;
               gap = int'($urandom_range(0, 3));
               if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
               do_req(0, rnd_a(), rnd_b());
            end
         end
         begin
            for (int k = 0; k < 12; k++) begin
               int gap;
               gap = int'($urandom_range(0, 3));
               if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
               do_req(1, rnd_a(), rnd_b());
            end
         end
      join
      wait_idle();
      chk("drain", sb.size(), 0);
      chk("spur_final", spurious_err, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
